// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int unsigned steps_f(input int unsigned width, input int unsigned k);
        return width / k;
    endfunction

    // One extra bit so the counter can hold STEPS itself after the final step.
    function automatic int unsigned ctr_w_f(input int unsigned steps);
        return 32'($clog2(steps)) + 32'd1;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned k);
        return (width >= 32'd2) && (k == 32'd1 || k == 32'd2 || k == 32'd4) && ((width % k) == 32'd0);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// Combinational step: adds BITS_PER_CYCLE shifted partial products of ma into acc.
module seq_mult_step
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic [WIDTH-1:0]                            ma,
    input  logic [WIDTH-1:0]                            mb,
    input  logic [ctr_w_f(steps_f(WIDTH, BITS_PER_CYCLE))-1:0] ctr,
    input  logic [2*WIDTH-1:0]                          acc,
    output logic [2*WIDTH-1:0]                          acc_next,
    output logic                                        rest_zero
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned K  = BITS_PER_CYCLE;

    logic [31:0]      shamt;
    logic [WIDTH-1:0] mb_shr;
    logic [PW-1:0]    pp_base;

    // Align multiplier slice to bit 0 and multiplicand to the slice's weight.
    always_comb begin
        shamt    = 32'(ctr) * K;
        mb_shr   = mb >> shamt;
        pp_base  = PW'(ma) << shamt;
        acc_next = acc;
        for (int unsigned k = 0; k < K; k++) begin
            if (mb_shr[k]) begin
                acc_next = acc_next + (pp_base << k);
            end
        end
        rest_zero = ((mb_shr >> K) == '0);
    end

endmodule

// File: rtl/seq_mult.sv
// Multi-cycle signed/unsigned shift-add multiplier with start/busy handshake and valid strobe.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter bit          EARLY_EXIT     = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]   b_bi,
    output logic [2*WIDTH-1:0] y_bo,
    output logic               busy_o,
    output logic               valid_o
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned STEPS = steps_f(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned CTR_W = ctr_w_f(STEPS);
    localparam logic [CTR_W-1:0] LAST = CTR_W'(STEPS - 1);

    if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
        $error("seq_mult: WIDTH must be >= 2 and BITS_PER_CYCLE in {1,2,4} dividing WIDTH");
    end

    state_t           state, state_next;
    logic [WIDTH-1:0] ma, ma_next;
    logic [WIDTH-1:0] mb, mb_next;
    logic             neg, neg_next;
    logic [PW-1:0]    acc, acc_next;
    logic [CTR_W-1:0] ctr, ctr_next;
    logic [PW-1:0]    y_next;
    logic             busy_next;
    logic             valid_next;
    logic [PW-1:0]    step_acc;
    logic             rest_zero;

    seq_mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .ma        (ma),
        .mb        (mb),
        .ctr       (ctr),
        .acc       (acc),
        .acc_next  (step_acc),
        .rest_zero (rest_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ma      <= '0;
            mb      <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            ctr     <= '0;
            y_bo    <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_next;
            ma      <= ma_next;
            mb      <= mb_next;
            neg     <= neg_next;
            acc     <= acc_next;
            ctr     <= ctr_next;
            y_bo    <= y_next;
            busy_o  <= busy_next;
            valid_o <= valid_next;
        end
    end

    // Operands are stored as magnitudes; the sign is reapplied once in FIX.
    always_comb begin
        state_next = state;
        ma_next    = ma;
        mb_next    = mb;
        neg_next   = neg;
        acc_next   = acc;
        ctr_next   = ctr;
        y_next     = y_bo;
        valid_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    ma_next    = (signed_i && a_bi[WIDTH-1]) ? (~a_bi + WIDTH'(1)) : a_bi;
                    mb_next    = (signed_i && b_bi[WIDTH-1]) ? (~b_bi + WIDTH'(1)) : b_bi;
                    neg_next   = signed_i & (a_bi[WIDTH-1] ^ b_bi[WIDTH-1]);
                    acc_next   = '0;
                    ctr_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                acc_next = step_acc;
                ctr_next = ctr + CTR_W'(1);
                if ((ctr == LAST) || (EARLY_EXIT && rest_zero)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                y_next     = neg ? (~acc + PW'(1)) : acc;
                valid_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_seq_mult.sv
// Directed bench for seq_mult: 8-bit K=1, 16-bit K=4 and 8-bit early-exit instances.
module tb_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        st0 = 1'b0, s0 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0;
    logic [15:0] y0;
    logic        busy0, valid0;

    logic        st1 = 1'b0, s1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic [31:0] y1;
    logic        busy1, valid1;

    logic        st2 = 1'b0, s2 = 1'b0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [15:0] y2;
    logic        busy2, valid2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(8), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(st0), .signed_i(s0),
        .a_bi(a0), .b_bi(b0), .y_bo(y0), .busy_o(busy0), .valid_o(valid0));

    seq_mult #(.WIDTH(16), .BITS_PER_CYCLE(4), .EARLY_EXIT(1'b0)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(st1), .signed_i(s1),
        .a_bi(a1), .b_bi(b1), .y_bo(y1), .busy_o(busy1), .valid_o(valid1));

    seq_mult #(.WIDTH(8), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b1)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(st2), .signed_i(s2),
        .a_bi(a2), .b_bi(b2), .y_bo(y2), .busy_o(busy2), .valid_o(valid2));

    typedef struct {
        int          d;
        logic [15:0] a;
        logic [15:0] b;
        bit          s;
        logic [31:0] y;
        int          cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic [15:0] a, input logic [15:0] b,
                         input bit s, input bit st);
        case (d)
            0: begin a0 = a[7:0]; b0 = b[7:0]; s0 = s; st0 = st; end
            1: begin a1 = a;      b1 = b;      s1 = s; st1 = st; end
            default: begin a2 = a[7:0]; b2 = b[7:0]; s2 = s; st2 = st; end
        endcase
    endtask

    function automatic logic [31:0] get_y(input int d);
        case (d)
            0: return 32'(y0);
            1: return y1;
            default: return 32'(y2);
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_valid(input int d);
        case (d)
            0: return valid0;
            1: return valid1;
            default: return valid2;
        endcase
    endfunction

    function automatic longint ext16(input logic [15:0] v, input bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Start one operation, count busy cycles, and check the valid pulse and result.
    task automatic run_op(input string tag, input int d, input logic [15:0] a, input logic [15:0] b,
                          input bit s, input logic [31:0] exp_y, input int exp_cyc);
        int cyc;
        bit early_valid;
        @(negedge clk);
        drive(d, a, b, s, 1'b1);
        @(negedge clk);
        drive(d, a, b, s, 1'b0);
        cyc = 0;
        early_valid = 1'b0;
        while (get_busy(d) && cyc < 64) begin
            cyc++;
            if (get_valid(d)) early_valid = 1'b1;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " valid_at_done"}, 32'(get_valid(d) & ~early_valid), 32'd1);
        check({tag, " y"}, get_y(d), exp_y);
        @(negedge clk);
        check({tag, " valid_drop"}, 32'(get_valid(d)), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  saw_valid;
        logic [15:0] ra, rb;
        bit  rs;

        vecs.push_back(vec_t'{0, 16'd200,   16'd3,    1'b0, 32'h0000_0258, 9});
        vecs.push_back(vec_t'{0, 16'h00FB,  16'h0007, 1'b1, 32'h0000_FFDD, 9});
        vecs.push_back(vec_t'{0, 16'h0080,  16'h0080, 1'b1, 32'h0000_4000, 9});
        vecs.push_back(vec_t'{0, 16'h0080,  16'h007F, 1'b1, 32'h0000_C080, 9});
        vecs.push_back(vec_t'{0, 16'h00FF,  16'h00FF, 1'b0, 32'h0000_FE01, 9});
        vecs.push_back(vec_t'{0, 16'h00FF,  16'h00FF, 1'b1, 32'h0000_0001, 9});
        vecs.push_back(vec_t'{0, 16'h0000,  16'h0080, 1'b1, 32'h0000_0000, 9});
        vecs.push_back(vec_t'{1, 16'hFFFF,  16'hFFFF, 1'b0, 32'hFFFE_0001, 5});
        vecs.push_back(vec_t'{1, 16'hFFFF,  16'hFFFF, 1'b1, 32'h0000_0001, 5});
        vecs.push_back(vec_t'{1, 16'h8000,  16'h7FFF, 1'b1, 32'hC000_8000, 5});
        vecs.push_back(vec_t'{1, 16'h1234,  16'h5678, 1'b0, 32'h0626_0060, 5});
        vecs.push_back(vec_t'{1, 16'hFFFE,  16'h0003, 1'b1, 32'hFFFF_FFFA, 5});
        vecs.push_back(vec_t'{2, 16'h00FF,  16'h0001, 1'b0, 32'h0000_00FF, 2});
        vecs.push_back(vec_t'{2, 16'h0037,  16'h0000, 1'b0, 32'h0000_0000, 2});
        vecs.push_back(vec_t'{2, 16'h0002,  16'h0080, 1'b0, 32'h0000_0100, 9});
        vecs.push_back(vec_t'{2, 16'h0003,  16'h0005, 1'b0, 32'h0000_000F, 4});
        vecs.push_back(vec_t'{2, 16'h00FF,  16'h00FF, 1'b1, 32'h0000_0001, 2});

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            vecs.push_back(vec_t'{1, ra, rb, rs, 32'(ext16(ra, rs) * ext16(rb, rs)), 5});
        end

        repeat (3) @(negedge clk);
        check("reset busy0", 32'(busy0), 32'd0);
        check("reset valid0", 32'(valid0), 32'd0);
        check("reset y0", 32'(y0), 32'd0);
        check("reset busy1", 32'(busy1), 32'd0);
        check("reset y1", y1, 32'd0);
        check("reset valid2", 32'(valid2), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].b,
                   vecs[i].s, vecs[i].y, vecs[i].cyc);
        end

        // start held high; operands change mid-operation; second op starts on the valid cycle
        @(negedge clk);
        drive(0, 16'd10, 16'd20, 1'b0, 1'b1);
        @(negedge clk);
        check("b2b busy_first", 32'(busy0), 32'd1);
        drive(0, 16'h00FD, 16'h0005, 1'b1, 1'b1);
        cyc = 1;
        while (!valid0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b first_latency", 32'(cyc), 32'd10);
        check("b2b first_y", 32'(y0), 32'h0000_00C8);
        check("b2b first_busy_low", 32'(busy0), 32'd0);
        @(negedge clk);
        check("b2b second_busy", 32'(busy0), 32'd1);
        check("b2b valid_single", 32'(valid0), 32'd0);
        drive(0, 16'h00FD, 16'h0005, 1'b1, 1'b0);
        cyc = 1;
        while (busy0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b second_busy_cycles", 32'(cyc - 1), 32'd9);
        check("b2b second_valid", 32'(valid0), 32'd1);
        check("b2b second_y", 32'(y0), 32'h0000_FFF1);

        // reset on the 4th CALC cycle discards the operation
        @(negedge clk);
        drive(0, 16'h00AA, 16'h0055, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 16'h00AA, 16'h0055, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst pre_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst busy", 32'(busy0), 32'd0);
        check("rst y", 32'(y0), 32'd0);
        check("rst valid", 32'(valid0), 32'd0);
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (valid0) saw_valid = 1'b1;
        end
        check("rst no_valid", 32'(saw_valid), 32'd0);
        run_op("post_rst 9x9", 0, 16'd9, 16'd9, 1'b0, 32'h0000_0051, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier; successor of the fixed 8-bit unsigned multiplier. It adds a configurable operand width, multiple multiplier bits per cycle, a per-operation signed/unsigned mode, optional early termination and a one-cycle result-valid strobe. It sits beside the ALU as a multi-cycle execution unit, driven by a start/busy handshake from the control logic.

## Interface
- `WIDTH`, default 8: operand width; result is 2*WIDTH. Legal values are ≥ 2.
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per step. Must be 1, 2 or 4 and must divide `WIDTH`.
- `EARLY_EXIT`, default 0: 1 ends the step phase once all remaining `b` bits are zero.
- Derived `STEPS` = `WIDTH`/`BITS_PER_CYCLE`.
- `clk_i`  in  1  clock; all logic updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  operation request; sampled only in IDLE.
- `signed_i`  in  1  1 = two's-complement operands; 0 = unsigned. Sampled with `start_i`.
- `a_bi`  in  `WIDTH`  multiplicand.
- `b_bi`  in  `WIDTH`  multiplier.
- `y_bo`  out  2*`WIDTH`  result register; holds its value until the next result is written.
- `busy_o`  out  1  high while state ≠ IDLE.
- `valid_o`  out  1  one-cycle pulse, coincident with the cycle `y_bo` first shows a new result.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE, `start_i`=1:**
  - Latch magnitudes: `ma` = (`signed_i` & `a`[MSB]) ? −a : a; `mb` likewise. Both are WIDTH-bit unsigned.
  - Set `neg` = `signed_i` & (a[MSB] ^ b[MSB]); clear `acc` and `ctr`.
  - Go to CALC.
- **IDLE, `start_i`=0:** hold.
- **CALC, each cycle:**
  - `acc` += Σ over k<`BITS_PER_CYCLE` of (`mb`[ctr*K+k] ? `ma` << (ctr*K+k) : 0), computed at 2*WIDTH bits (K = `BITS_PER_CYCLE`).
  - `ctr` += 1.
  - Go to FIX when `ctr` == `STEPS`−1, or when `EARLY_EXIT` is set and `mb` >> ((ctr+1)*K) == 0. Otherwise stay in CALC.
- **FIX:**
  - `y_bo` ← `neg` ? −`acc` : `acc` (2*WIDTH wrap-around negation).
  - `valid_o` ← 1; go to IDLE.
- **Width rules:**
  - Magnitude of the most negative value (e.g. −128 at WIDTH=8) is 2^(WIDTH−1) and fits unsigned in WIDTH bits.
  - The full product always fits in 2*WIDTH bits; there is no overflow flag.
- **Boundary conditions:**
  - `start_i` while busy is ignored; operands and `signed_i` may change freely during busy.
  - `start_i` in the IDLE cycle that shows `valid_o` is accepted (back-to-back operation).
  - Zero operands produce 0 regardless of `neg`.
- **Reset:** applies in any state. State → IDLE, `ctr` and `acc` → 0, `y_bo` → 0, `busy_o` → 0, `valid_o` → 0. An in-flight operation is discarded and no `valid_o` is produced.

## Timing
- Edge E0 samples `start_i`=1; `busy_o`=1 from E0.
- CALC occupies edges E1..En, where n = `STEPS` (n ≤ `STEPS` with `EARLY_EXIT`, minimum 1).
- Edge En+1 (FIX):
  - writes `y_bo`;
  - `valid_o`=1 and `busy_o`=0 after this edge.
- `busy_o` is therefore high for n+1 cycles. WIDTH=8, K=1, no early exit gives 9 cycles, the same as the predecessor.
- `valid_o` deasserts on the following edge.
- Adder path: K shifted partial products into a 2*WIDTH accumulator in one cycle. K=4 is the timing ceiling.

## Structure
- Package `seq_mult_pkg` holds:
  - state encoding localparams IDLE/CALC/FIX (2 bits);
  - the `STEPS` and counter-width (clog2(`STEPS`)+1) helper functions;
  - parameter-legality checks.
- One sub-module, `seq_mult_step`: combinational K-bit partial-product generator and adder (`ma`, `mb` slice, `ctr`, `acc` → `acc_next`, `rest_zero`).
- The FSM, operand and `neg` registers, output registers and sign fix-up stay in the top level.

## Test plan
- WIDTH=8, K=1, unsigned, a=200, b=3 → `y_bo`=0x0258; `busy_o` high exactly 9 cycles; `valid_o` pulses once on the cycle `busy_o` falls.
- WIDTH=8, signed: −5×7 → 0xFFDD; −128×−128 → 0x4000; −128×127 → 0xC080. Unsigned 0xFF×0xFF → 0xFE01.
- WIDTH=16, K=4: 0xFFFF×0xFFFF unsigned → 0xFFFE0001 with `busy_o` high 5 cycles. Random signed/unsigned pairs match a reference model.
- `EARLY_EXIT`=1, WIDTH=8:
  - a=0xFF, b=0x01 → 0x00FF with `busy_o` high 2 cycles;
  - b=0 → 0 after 2 cycles;
  - b=0x80 → full 9 cycles.
- `start_i` held high throughout with operands changed mid-operation:
  - first result is unaffected;
  - second operation starts on the `valid_o` cycle;
  - results come back-to-back with no idle gap.
- `rst_i` asserted on the 4th CALC cycle → next edge `busy_o`=0, `y_bo`=0, no `valid_o`. A following operation 9×9 returns 0x0051.
